// File: rtl/avalon_ram_responder_pkg.sv
// avalon_ram_responder_pkg: shared Avalon-MM request/response types and lane
// constants, plus the wait-state FSM encoding used by the responder.
package avalon_ram_responder_pkg;

  localparam int AVN_AW = 32;          // byte address width on the bus
  localparam int AVN_DW = 32;          // bus data width
  localparam int AVN_BE = AVN_DW / 8;  // byte lanes

  typedef struct packed {
    logic              read;
    logic              write;
    logic [AVN_AW-1:0] address;
    logic [AVN_DW-1:0] writedata;
    logic [AVN_BE-1:0] byte_enable;
  } avalon_req_t;

  typedef struct packed {
    logic [AVN_DW-1:0] readdata;
    logic              readdatavalid;
    logic              waitrequest;
  } avalon_resp_t;

  typedef enum logic [1:0] {
    WS_IDLE,
    WS_WAIT,
    WS_GRANT
  } ws_state_t;

endpackage

// File: rtl/avalon_ram_responder_if.sv
// avalon_ram_responder_if: request/response bundle between an Avalon-MM
// initiator (master) and the RAM responder (slave).
interface avalon_ram_responder_if;
  import avalon_ram_responder_pkg::*;

  avalon_req_t  req;
  avalon_resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);

endinterface

// File: rtl/avalon_ram_responder_ram_1rw_be.sv
// avalon_ram_responder_ram_1rw_be: inferable single-port word RAM with
// per-byte write enables and a registered read port. The read register only
// loads on a read, so its value holds between reads.
module avalon_ram_responder_ram_1rw_be #(
  parameter int AW = 14,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic            re_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW-1:0]   wdata_i,
  output logic [DW-1:0]   rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Byte-lane writes; lanes with byte enable low keep their contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DW/8; i++) begin
      if (we_i && be_i[i]) mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
    end
  end

  // Registered read port; reset clears only the output register, never the array.
  always_ff @(posedge clk) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/avalon_ram_responder.sv
// avalon_ram_responder: Avalon-MM responder memory. One request per cycle,
// reads return after READ_LATENCY cycles in issue order, write wins over a
// simultaneous read. Optional wait-state FSM enabled by AVN_RAM_WAITSTATE_EN.
module avalon_ram_responder
  import avalon_ram_responder_pkg::*;
#(
  parameter int AW           = 14,
  parameter int DW           = AVN_DW,
  parameter int READ_LATENCY = 1,
  parameter int WAIT_CYCLES  = 2
) (
  input logic                   clk,
  input logic                   rst,
  avalon_ram_responder_if.slave avl
);

  logic                    req_any;
  logic                    waitrequest;
  logic                    accept;
  logic                    rd_acc;
  logic                    wr_acc;
  logic [AW-1:0]           word_idx;
  logic [DW-1:0]           ram_rdata;
  logic [DW-1:0]           readdata;
  logic [READ_LATENCY-1:0] vld_q;
  logic                    unused_addr_bits;

  assign req_any  = avl.req.read | avl.req.write;
  assign accept   = req_any & ~waitrequest & ~rst;
  assign rd_acc   = accept & avl.req.read & ~avl.req.write;
  assign wr_acc   = accept & avl.req.write;
  assign word_idx = avl.req.address[AW+1:2];
  // Byte offset and bits above the RAM depth alias silently.
  assign unused_addr_bits = ^{avl.req.address[AVN_AW-1:AW+2], avl.req.address[1:0]};

  avalon_ram_responder_ram_1rw_be #(.AW(AW), .DW(DW)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_acc),
    .re_i    (rd_acc),
    .be_i    (avl.req.byte_enable),
    .addr_i  (word_idx),
    .wdata_i (avl.req.writedata),
    .rdata_o (ram_rdata)
  );

  // Valid shift register: bit k set means a read beat is k+1 cycles old.
  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= (vld_q << 1) | READ_LATENCY'(rd_acc);
  end

  if (READ_LATENCY == 1) begin : g_rl1
    assign readdata = ram_rdata;
  end else begin : g_rln
    for (genvar k = 0; k < READ_LATENCY-1; k++) begin : g_stg
      logic [DW-1:0] dat_d;
      logic [DW-1:0] dat_q;
      if (k == 0) begin : g_src0
        assign dat_d = ram_rdata;
      end else begin : g_srcn
        assign dat_d = g_stg[k-1].dat_q;
      end
      // Middle stages shift freely; the last stage loads only on a valid beat so readdata holds.
      always_ff @(posedge clk) begin
        if (rst)                                    dat_q <= '0;
        else if ((k != READ_LATENCY-2) || vld_q[k]) dat_q <= dat_d;
      end
    end
    assign readdata = g_stg[READ_LATENCY-2].dat_q;
  end

`ifdef AVN_RAM_WAITSTATE_EN
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  ws_state_t     state_q;
  logic [CW-1:0] cnt_q;
  logic          wait_q;

  // Wait-state FSM. waitrequest is registered, so it is already high in IDLE
  // when a request shows up; the count is checked on its next value so the
  // grant lands exactly WAIT_CYCLES cycles after the request first appears.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WS_IDLE;
      cnt_q   <= '0;
      wait_q  <= 1'b1;
    end else if (WAIT_CYCLES == 0) begin
      state_q <= WS_IDLE;
      wait_q  <= 1'b0;
    end else begin
      case (state_q)
        WS_IDLE: begin
          if (req_any) begin
            if (WAIT_CYCLES == 1) begin
              state_q <= WS_GRANT;
              wait_q  <= 1'b0;
            end else begin
              state_q <= WS_WAIT;
              cnt_q   <= CW'(WAIT_CYCLES - 1);
            end
          end
        end
        WS_WAIT: begin
          if (!req_any) begin
            state_q <= WS_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
              state_q <= WS_GRANT;
              wait_q  <= 1'b0;
            end
          end
        end
        WS_GRANT: begin
          state_q <= WS_IDLE;
          wait_q  <= 1'b1;
        end
        default: begin
          state_q <= WS_IDLE;
          wait_q  <= 1'b1;
        end
      endcase
    end
  end

  assign waitrequest = wait_q;
`else
  localparam int unused_wait_cycles = WAIT_CYCLES;
  assign waitrequest = 1'b0;
`endif

  assign avl.resp = '{readdata: readdata, readdatavalid: vld_q[READ_LATENCY-1], waitrequest: waitrequest};

endmodule

// File: tb/tb_avalon_ram_responder.sv
// tb_avalon_ram_responder: two responders (READ_LATENCY 1 and 2) driven in
// lockstep, checked every cycle against a queue/array memory model.
module tb_avalon_ram_responder;
  import avalon_ram_responder_pkg::*;

  localparam int AW = 14;

  typedef struct { int due; logic [31:0] data; } beat_t;
  typedef struct {
    logic rd; logic wr; logic [31:0] addr; logic [31:0] wd; logic [3:0] be; logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  avalon_req_t req_drv = '0;

  avalon_ram_responder_if if1();
  avalon_ram_responder_if if2();
  assign if1.req = req_drv;
  assign if2.req = req_drv;

  avalon_ram_responder #(.AW(AW), .DW(32), .READ_LATENCY(1), .WAIT_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .avl(if1));
  avalon_ram_responder #(.AW(AW), .DW(32), .READ_LATENCY(2), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .avl(if2));

  always #5 clk = ~clk;

  logic [31:0] mdl [bit [AW-1:0]];
  beat_t       q1[$];
  beat_t       q2[$];
  logic [31:0] last1 = '0, last2 = '0;
  int          cyc = 0, n_tests = 0, n_fail = 0;
  bit          beat1_seen;
  logic [31:0] beat1_data;
  int          b2_cyc[$];
  logic [31:0] b2_dat[$];
  logic        wr_seen;

  function automatic logic [31:0] pre(input int idx);
    return 32'h5A00_0000 + 32'(idx) * 32'h0011_0101;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_resp(input string tag, input avalon_resp_t r, input bit due,
                            input logic [31:0] exp_d, input logic [31:0] hold_d);
    chk({tag, "_valid"}, {31'b0, r.readdatavalid}, {31'b0, due});
    chk({tag, due ? "_data" : "_hold"}, r.readdata, due ? exp_d : hold_d);
  endtask

  // One clock cycle: check this cycle's outputs, then drive the next inputs and update the model.
  task automatic step(input bit rs, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be, output bit acc);
    bit due1, due2;
    logic [AW-1:0] idx;
    logic [31:0] w;
    @(negedge clk);
    due1 = (q1.size() > 0) && (q1[0].due == cyc);
    due2 = (q2.size() > 0) && (q2[0].due == cyc);
    check_resp("rl1", if1.resp, due1, due1 ? q1[0].data : 32'h0, last1);
    check_resp("rl2", if2.resp, due2, due2 ? q2[0].data : 32'h0, last2);
    if (due1) begin
      last1 = q1[0].data; beat1_seen = 1'b1; beat1_data = if1.resp.readdata; void'(q1.pop_front());
    end
    if (due2) begin
      last2 = q2[0].data; void'(q2.pop_front());
    end
    if (if2.resp.readdatavalid) begin
      b2_cyc.push_back(cyc); b2_dat.push_back(if2.resp.readdata);
    end
`ifndef AVN_RAM_WAITSTATE_EN
    chk("waitrequest", {31'b0, if1.resp.waitrequest}, 32'h0);
`endif
    rst = rs;
    req_drv = '{read: rd, write: wr, address: a, writedata: wd, byte_enable: be};
    wr_seen = if1.resp.waitrequest;
    acc = !rs && (rd || wr) && !if1.resp.waitrequest;
    idx = a[AW+1:2];
    if (rs) begin
      q1.delete(); q2.delete(); last1 = '0; last2 = '0;
    end else if (acc) begin
      if (wr) begin
        w = mdl.exists(idx) ? mdl[idx] : 32'h0;
        for (int i = 0; i < 4; i++) if (be[i]) w[i*8 +: 8] = wd[i*8 +: 8];
        mdl[idx] = w;
      end else begin
        q1.push_back('{due: cyc + 1, data: mdl[idx]});
        q2.push_back('{due: cyc + 2, data: mdl[idx]});
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, acc);
  endtask

  // Holds a request until it is accepted (bounded).
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      step(1'b0, rd, wr, a, wd, be, acc);
      n++;
    end
    if (!acc) begin
      n_tests++; n_fail++;
      $display("FAIL req_timeout: request at %h never accepted", a);
    end
  endtask

  vec_t vt[11];
  bit   acc_g;
  int   k_acc;
  logic wr_hist[4];
  int   c0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0};
    vt[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_BEEF};
    vt[2]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h1122_3344, 4'b0101, 32'h0};
    vt[3]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDE22_BE44};
    vt[4]  = '{1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'b1111, 32'h0};
    vt[5]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         4'b0000, 32'hCAFE_F00D};
    vt[6]  = '{1'b1, 1'b0, 32'h0001_0023, 32'h0,         4'b0000, 32'hCAFE_F00D};
    vt[7]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 32'h0};
    vt[8]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDE22_BE44};
    vt[9]  = '{1'b0, 1'b1, 32'h0000_0014, 32'hAABB_CCDD, 4'b1000, 32'h0};
    vt[10] = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,         4'b0000, 32'hAA55_0505};

    // Reset, then reset-state check.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, acc_g);
    idle(1);
    chk("reset_rdata_rl1", if1.resp.readdata, 32'h0);
    chk("reset_rdata_rl2", if2.resp.readdata, 32'h0);

    // Preload a pool of 16 words.
    for (int i = 0; i < 16; i++) do_req(1'b0, 1'b1, 32'(i * 4), pre(i), 4'hF);
    idle(2);

    // Table-driven directed vectors.
    foreach (vt[i]) begin
      do_req(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wd, vt[i].be);
      beat1_seen = 1'b0;
      if (vt[i].rd && vt[i].wr) begin
        idle(3);
        chk("rw_no_valid", {31'b0, beat1_seen}, 32'h0);
      end else if (vt[i].rd) begin
        for (int n = 0; n < 8 && !beat1_seen; n++) idle(1);
        chk("vec_valid_seen", {31'b0, beat1_seen}, 32'h1);
        chk($sformatf("vec%0d_data", i), beat1_data, vt[i].exp);
      end
    end
    idle(3);

    // READ_LATENCY=2 back-to-back reads: beats on three consecutive cycles, in order.
    b2_cyc.delete(); b2_dat.delete();
    c0 = cyc;
    do_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    do_req(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    do_req(1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    idle(5);
    chk("b2b_count", 32'(b2_cyc.size()), 32'd3);
    for (int i = 0; i < 3 && i < b2_cyc.size(); i++) begin
`ifndef AVN_RAM_WAITSTATE_EN
      chk($sformatf("b2b_cycle%0d", i), 32'(b2_cyc[i]), 32'(c0 + 2 + i));
`endif
      chk($sformatf("b2b_data%0d", i), b2_dat[i], pre(i));
    end

    // Reset the cycle after a read is accepted: in-flight beats vanish, RAM keeps its data.
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, acc_g);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, acc_g);
    chk("rst_rdv_rl2", {31'b0, if2.resp.readdatavalid}, 32'h0);
    chk("rst_rdata_rl1", if1.resp.readdata, 32'h0);
    chk("rst_rdata_rl2", if2.resp.readdata, 32'h0);
    idle(3);
    beat1_seen = 1'b0;
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    idle(3);
    chk("rst_ram_kept", beat1_data, 32'hDE22_BE44);

`ifdef AVN_RAM_WAITSTATE_EN
    // WAIT_CYCLES=2: waitrequest high in cycles 0 and 1, accept in cycle 2, data in cycle 3.
    idle(2);
    k_acc = -1;
    foreach (wr_hist[k]) wr_hist[k] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, acc_g);
      wr_hist[k] = wr_seen;
      if (acc_g) begin
        k_acc = k;
        break;
      end
    end
    chk("ws_wreq_c0", {31'b0, wr_hist[0]}, 32'h1);
    chk("ws_wreq_c1", {31'b0, wr_hist[1]}, 32'h1);
    chk("ws_accept_cycle", 32'(k_acc), 32'd2);
    beat1_seen = 1'b0;
    idle(1);
    chk("ws_valid_c3", {31'b0, beat1_seen}, 32'h1);
    // Withdrawn during the wait: nothing is performed.
    step(1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 4'hF, acc_g);
    idle(4);
`endif

    // Randomized traffic over the pool with aliased addresses.
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      a = ($urandom & 32'hFFFF_0003) | (32'($urandom_range(0, 15)) << 2);
      step(1'b0, (r >= 3 && r <= 6) || r == 9, r >= 7, a, $urandom, 4'($urandom), acc_g);
    end
    idle(6);
    chk("drain_q1", 32'(q1.size()), 32'h0);
    chk("drain_q2", 32'(q2.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
